// File: rtl/imem_responder_if.sv
// Fetch-side request/response bundle for the instruction memory responder.
// Master is the fetch stage, slave is the responder.
interface imem_responder_if #(
  parameter int N = 64,
  parameter int W = 32
);
  logic         req_valid_F;
  logic [N-1:0] req_addr_F;
  logic         req_ready_F;
  logic         resp_valid_F;
  logic [W-1:0] resp_instr_F;
  logic         resp_fault_F;
  logic [1:0]   resp_cause_F;

  modport master (
    output req_valid_F,
    output req_addr_F,
    input  req_ready_F,
    input  resp_valid_F,
    input  resp_instr_F,
    input  resp_fault_F,
    input  resp_cause_F
  );

  modport slave (
    input  req_valid_F,
    input  req_addr_F,
    output req_ready_F,
    output resp_valid_F,
    output resp_instr_F,
    output resp_fault_F,
    output resp_cause_F
  );
endinterface

// File: rtl/imem_responder.sv
// Instruction memory responder: fixed-latency word fetch with
// misaligned / out-of-range fault reporting and a loader write port.
module imem_responder #(
  parameter int N     = 64,
  parameter int W     = 32,
  parameter int DEPTH = 64,
  parameter int LAT   = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  imem_responder_if.slave          bus,
  input  logic                     prog_we,
  input  logic [$clog2(DEPTH)-1:0] prog_idx,
  input  logic [W-1:0]             prog_data,
  output logic                     busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (LAT > 2) ? $clog2(LAT - 1) : 1;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [W-1:0]  instr_q, instr_d;
  logic          fault_q, fault_d;
  logic [1:0]    cause_q, cause_d;
  logic          valid_q, valid_d;

  logic [W-1:0]  mem [DEPTH];

  logic          mis;
  logic          oor;
  logic [AW-1:0] req_idx;

  // Range check looks at every upper bit so high addresses never alias.
  assign mis     = |bus.req_addr_F[1:0];
  assign oor     = |(bus.req_addr_F >> (AW + 2));
  assign req_idx = bus.req_addr_F[AW+1:2];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    instr_d = instr_q;
    fault_d = fault_q;
    cause_d = cause_q;
    valid_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.req_valid_F) begin
          idx_d = req_idx;
          if (mis || oor) begin
            state_d = RESP;
            valid_d = 1'b1;
            fault_d = 1'b1;
            instr_d = '0;
            cause_d = mis ? 2'b01 : 2'b10;
          end else if (LAT == 1) begin
            state_d = RESP;
            valid_d = 1'b1;
            fault_d = 1'b0;
            cause_d = 2'b00;
            instr_d = mem[req_idx];
          end else begin
            state_d = ACCESS;
            cnt_d   = CW'(LAT > 1 ? LAT - 2 : 0);
          end
        end
      end
      ACCESS: begin
        if (cnt_q == '0) begin
          state_d = RESP;
          valid_d = 1'b1;
          fault_d = 1'b0;
          cause_d = 2'b00;
          instr_d = mem[idx_q];
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      instr_q <= '0;
      fault_q <= 1'b0;
      cause_q <= 2'b00;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      instr_q <= instr_d;
      fault_q <= fault_d;
      cause_q <= cause_d;
      valid_q <= valid_d;
    end
  end

  // Storage is not reset; a same-edge capture sees the old word.
  always_ff @(posedge clk) begin
    if (prog_we) begin
      mem[prog_idx] <= prog_data;
    end
  end

  assign bus.req_ready_F  = (state_q == IDLE);
  assign bus.resp_valid_F = valid_q;
  assign bus.resp_instr_F = instr_q;
  assign bus.resp_fault_F = fault_q;
  assign bus.resp_cause_F = cause_q;
  assign busy             = (state_q != IDLE);

endmodule

// File: tb/tb_imem_responder.sv
// Scoreboard bench for imem_responder at LAT=2, plus LAT=1 and LAT=4
// instances exercised side by side for latency placement.
module tb_imem_responder;

  typedef struct packed {
    int unsigned cyc;
    logic [31:0] instr;
    logic        fault;
    logic [1:0]  cause;
  } rsp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        prog_we = 1'b0;
  logic [5:0]  prog_idx = '0;
  logic [31:0] prog_data = '0;
  logic        busy1, busy2, busy4;

  int unsigned cyc = 0;
  int          checks = 0;
  int          errors = 0;

  logic [31:0] shadow [64];
  rsp_t exp1_q[$], exp2_q[$], exp4_q[$];
  rsp_t got1_q[$], got2_q[$], got4_q[$];

  imem_responder_if #(.N(64), .W(32)) if_l1();
  imem_responder_if #(.N(64), .W(32)) if_l2();
  imem_responder_if #(.N(64), .W(32)) if_l4();

  imem_responder #(.N(64), .W(32), .DEPTH(64), .LAT(1)) u_dut1 (
    .clk(clk), .reset(reset), .bus(if_l1), .prog_we(prog_we),
    .prog_idx(prog_idx), .prog_data(prog_data), .busy(busy1));
  imem_responder #(.N(64), .W(32), .DEPTH(64), .LAT(2)) u_dut2 (
    .clk(clk), .reset(reset), .bus(if_l2), .prog_we(prog_we),
    .prog_idx(prog_idx), .prog_data(prog_data), .busy(busy2));
  imem_responder #(.N(64), .W(32), .DEPTH(64), .LAT(4)) u_dut4 (
    .clk(clk), .reset(reset), .bus(if_l4), .prog_we(prog_we),
    .prog_idx(prog_idx), .prog_data(prog_data), .busy(busy4));

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (if_l1.resp_valid_F)
      got1_q.push_back(rsp_t'{cyc, if_l1.resp_instr_F,
                              if_l1.resp_fault_F, if_l1.resp_cause_F});
    if (if_l2.resp_valid_F)
      got2_q.push_back(rsp_t'{cyc, if_l2.resp_instr_F,
                              if_l2.resp_fault_F, if_l2.resp_cause_F});
    if (if_l4.resp_valid_F)
      got4_q.push_back(rsp_t'{cyc, if_l4.resp_instr_F,
                              if_l4.resp_fault_F, if_l4.resp_cause_F});
  end

  // c is the cycle count seen just before the accepting edge.
  function automatic rsp_t model(input logic [63:0] a,
                                 input int unsigned c,
                                 input int unsigned lat);
    rsp_t r;
    r.cyc   = c + 1;
    r.instr = '0;
    r.fault = 1'b1;
    if (a[1:0] != 2'b00) begin
      r.cause = 2'b01;
    end else if ((a >> 2) >= 64) begin
      r.cause = 2'b10;
    end else begin
      r.cyc   = c + lat;
      r.instr = shadow[a[7:2]];
      r.fault = 1'b0;
      r.cause = 2'b00;
    end
    return r;
  endfunction

  task automatic prog(input logic [5:0] idx, input logic [31:0] data);
    prog_we   = 1'b1;
    prog_idx  = idx;
    prog_data = data;
    @(negedge clk);
    prog_we   = 1'b0;
    shadow[idx] = data;
  endtask

  task automatic send(input logic [63:0] a, input bit keep);
    int n = 0;
    if_l2.req_valid_F = 1'b1;
    if_l2.req_addr_F  = a;
    while (!if_l2.req_ready_F && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 50) begin
      errors++;
      $display("FAIL accept_timeout addr %h ready %b want 1",
               a, if_l2.req_ready_F);
    end
    exp2_q.push_back(model(a, cyc, 2));
    @(negedge clk);
    if (!keep) if_l2.req_valid_F = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if (if_l2.req_ready_F !== 1'b1 || busy2 !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready_busy got %b%b want 10",
               if_l2.req_ready_F, busy2);
    end
    checks++;
    if ({if_l2.resp_valid_F, if_l2.resp_instr_F,
         if_l2.resp_fault_F, if_l2.resp_cause_F} !== 36'h0) begin
      errors++;
      $display("FAIL reset_resp got %b %h %b %b want zeros",
               if_l2.resp_valid_F, if_l2.resp_instr_F,
               if_l2.resp_fault_F, if_l2.resp_cause_F);
    end
    checks++;
    if ({if_l1.req_ready_F, busy1, if_l1.resp_valid_F,
         if_l4.req_ready_F, busy4, if_l4.resp_valid_F} !== 6'b100100) begin
      errors++;
      $display("FAIL reset_variants got %b%b%b%b%b%b want 100100",
               if_l1.req_ready_F, busy1, if_l1.resp_valid_F,
               if_l4.req_ready_F, busy4, if_l4.resp_valid_F);
    end
  endtask

  task automatic test_legal();
    rsp_t e, g;
    int n = 0;
    send(64'h0, 1'b0);
    checks++;
    if (if_l2.req_ready_F !== 1'b0 || busy2 !== 1'b1) begin
      errors++;
      $display("FAIL legal_ready_t1 got %b%b want 01",
               if_l2.req_ready_F, busy2);
    end
    @(negedge clk);
    checks++;
    if (if_l2.req_ready_F !== 1'b0) begin
      errors++;
      $display("FAIL legal_ready_t2 got %b want 0", if_l2.req_ready_F);
    end
    send(64'h4, 1'b0);
    while (got2_q.size() < exp2_q.size() && n < 20) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    while (exp2_q.size() > 0) begin
      e = exp2_q.pop_front();
      g = (got2_q.size() > 0) ? got2_q.pop_front() : '0;
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL legal_resp got %h want %h", g, e);
      end
    end
    checks++;
    if (got2_q.size() != 0) begin
      errors++;
      $display("FAIL legal_extra got %0d want 0", got2_q.size());
      got2_q.delete();
    end
    checks++;
    if (if_l2.resp_instr_F !== 32'hF840_0041) begin
      errors++;
      $display("FAIL legal_hold got %h want f8400041", if_l2.resp_instr_F);
    end
  endtask

  task automatic test_fault();
    rsp_t e, g;
    int n = 0;
    send(64'h6, 1'b0);
    send(64'h100, 1'b0);
    send(64'hFC, 1'b0);
    send(64'hFFFF_FFFF_FFFF_FFFC, 1'b0);
    send(64'h1, 1'b0);
    while (got2_q.size() < exp2_q.size() && n < 30) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    while (exp2_q.size() > 0) begin
      e = exp2_q.pop_front();
      g = (got2_q.size() > 0) ? got2_q.pop_front() : '0;
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL fault_resp got %h want %h", g, e);
      end
    end
    checks++;
    if (got2_q.size() != 0) begin
      errors++;
      $display("FAIL fault_extra got %0d want 0", got2_q.size());
      got2_q.delete();
    end
  endtask

  task automatic test_back_to_back();
    rsp_t e, g;
    int n = 0;
    send(64'h0, 1'b1);
    send(64'h8, 1'b0);
    while (got2_q.size() < exp2_q.size() && n < 20) begin
      @(negedge clk);
      n++;
    end
    repeat (4) @(negedge clk);
    while (exp2_q.size() > 0) begin
      e = exp2_q.pop_front();
      g = (got2_q.size() > 0) ? got2_q.pop_front() : '0;
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL b2b_resp got %h want %h", g, e);
      end
    end
    checks++;
    if (got2_q.size() != 0) begin
      errors++;
      $display("FAIL b2b_extra got %0d want 0", got2_q.size());
      got2_q.delete();
    end
  endtask

  task automatic test_rbw();
    rsp_t e, g;
    int n = 0;
    send(64'h8, 1'b0);
    // Next edge captures word 2 and also writes it.
    prog(6'd2, 32'hAAAA_AAAA);
    repeat (2) @(negedge clk);
    send(64'h8, 1'b0);
    while (got2_q.size() < exp2_q.size() && n < 20) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    while (exp2_q.size() > 0) begin
      e = exp2_q.pop_front();
      g = (got2_q.size() > 0) ? got2_q.pop_front() : '0;
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL rbw_resp got %h want %h", g, e);
      end
    end
    checks++;
    if (got2_q.size() != 0) begin
      errors++;
      $display("FAIL rbw_extra got %0d want 0", got2_q.size());
      got2_q.delete();
    end
  endtask

  task automatic test_reset_abort();
    rsp_t e, g;
    int n = 0;
    if_l2.req_valid_F = 1'b1;
    if_l2.req_addr_F  = 64'h0;
    @(negedge clk);
    if_l2.req_valid_F = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if ({busy2, if_l2.req_ready_F, if_l2.resp_valid_F} !== 3'b010) begin
      errors++;
      $display("FAIL abort_state got %b%b%b want 010",
               busy2, if_l2.req_ready_F, if_l2.resp_valid_F);
    end
    checks++;
    if (if_l2.resp_instr_F !== 32'h0) begin
      errors++;
      $display("FAIL abort_instr got %h want 0", if_l2.resp_instr_F);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (got2_q.size() != 0) begin
      errors++;
      $display("FAIL abort_pulse got %0d want 0", got2_q.size());
      got2_q.delete();
    end
    send(64'h0, 1'b0);
    while (got2_q.size() < exp2_q.size() && n < 20) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    while (exp2_q.size() > 0) begin
      e = exp2_q.pop_front();
      g = (got2_q.size() > 0) ? got2_q.pop_front() : '0;
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL abort_refetch got %h want %h", g, e);
      end
    end
  endtask

  task automatic test_lat_variants();
    rsp_t e, g;
    logic [63:0] addrs [4];
    addrs[0] = 64'h4;
    addrs[1] = 64'h2;
    addrs[2] = 64'h100;
    addrs[3] = 64'hFC;
    foreach (addrs[i]) begin
      if_l1.req_valid_F = 1'b1;
      if_l1.req_addr_F  = addrs[i];
      if_l4.req_valid_F = 1'b1;
      if_l4.req_addr_F  = addrs[i];
      checks++;
      if (if_l1.req_ready_F !== 1'b1 || if_l4.req_ready_F !== 1'b1) begin
        errors++;
        $display("FAIL var_ready got %b%b want 11",
                 if_l1.req_ready_F, if_l4.req_ready_F);
      end
      exp1_q.push_back(model(addrs[i], cyc, 1));
      exp4_q.push_back(model(addrs[i], cyc, 4));
      @(negedge clk);
      if_l1.req_valid_F = 1'b0;
      if_l4.req_valid_F = 1'b0;
      repeat (7) @(negedge clk);
    end
    while (exp1_q.size() > 0) begin
      e = exp1_q.pop_front();
      g = (got1_q.size() > 0) ? got1_q.pop_front() : '0;
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL lat1_resp got %h want %h", g, e);
      end
    end
    while (exp4_q.size() > 0) begin
      e = exp4_q.pop_front();
      g = (got4_q.size() > 0) ? got4_q.pop_front() : '0;
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL lat4_resp got %h want %h", g, e);
      end
    end
    checks++;
    if (got1_q.size() != 0 || got4_q.size() != 0) begin
      errors++;
      $display("FAIL var_extra got %0d/%0d want 0/0",
               got1_q.size(), got4_q.size());
    end
  endtask

  initial begin
    if_l1.req_valid_F = 1'b0;
    if_l1.req_addr_F  = '0;
    if_l2.req_valid_F = 1'b0;
    if_l2.req_addr_F  = '0;
    if_l4.req_valid_F = 1'b0;
    if_l4.req_addr_F  = '0;
    foreach (shadow[i]) shadow[i] = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    test_reset();
    prog(6'd0, 32'h8B02_0020);
    prog(6'd1, 32'hF840_0041);
    prog(6'd2, 32'h1111_1111);
    prog(6'd63, 32'h0DEF_0063);
    test_legal();
    test_fault();
    test_back_to_back();
    test_rbw();
    test_reset_abort();
    test_lat_variants();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
